noc_rx_port: RTL and testbench



---
 rtl/noc_rx_port.sv | 162 ++++++++++++++++
 tb/tb_noc_rx_port.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_rx_port.sv
// Receive-side NoC endpoint: parses packet headers from the local router port,
// drops packets addressed to other nodes, and buffers payload words with their
// source ID in a first-word-fall-through FIFO popped by the core.
// Optional: define NOC_RX_PARITY_EN to add even-parity checking (flit_par, par_err).
module noc_rx_port #(
  parameter int unsigned NODE_ID    = 0,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PTR_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] flit_in,
  input  logic        flit_valid,
  output logic        flit_ready,
  input  logic        cpu_rd_en,
  output logic [31:0] cpu_rd_data,
  output logic [3:0]  cpu_rd_src,
  output logic        cpu_empty,
  output logic        cpu_stall,
  output logic        pkt_done,
  output logic [7:0]  drop_cnt
`ifdef NOC_RX_PARITY_EN
  ,
  input  logic        flit_par,
  output logic        par_err
`endif
);

  localparam logic [3:0] LpNodeId = 4'(NODE_ID);

  typedef enum logic [1:0] {StIdle, StPayload, StDrop} state_e;

  state_e      r_state, w_state_next;
  logic [7:0]  r_rem, w_rem_next;
  logic [3:0]  r_src, w_src_next;
  logic        r_pkt_done, w_pkt_done_next;
  logic [7:0]  r_drop_cnt;
  logic        w_drop_inc;
  logic        w_push, w_pop, w_xfer;
  logic        w_full, w_empty;
  logic        w_par_ok;
  logic        w_hdr_keep;
  logic [PTR_W:0] r_wptr, r_rptr;
  logic [35:0] r_mem [FIFO_DEPTH];
  logic [35:0] w_head;

`ifdef NOC_RX_PARITY_EN
  logic r_par_err;
  // Even parity: flit bits plus parity bit must hold an even number of ones.
  assign w_par_ok = ~(^{flit_in, flit_par});
  assign par_err  = r_par_err;
`else
  assign w_par_ok = 1'b1;
`endif

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_xfer  = flit_valid && flit_ready;
  assign w_pop   = cpu_rd_en && !w_empty;
  // A header is kept only if it targets this node and arrived intact.
  assign w_hdr_keep = (flit_in[31:28] == LpNodeId) && w_par_ok;

  assign w_head      = r_mem[r_rptr[PTR_W-1:0]];
  assign cpu_rd_data = w_head[31:0];
  assign cpu_rd_src  = w_head[35:32];
  assign cpu_empty   = w_empty;
  assign cpu_stall   = cpu_rd_en && w_empty;
  assign pkt_done    = r_pkt_done;
  assign drop_cnt    = r_drop_cnt;

  // Next-state, handshake and FIFO push decode for the header/payload parser.
  always_comb begin
    w_state_next    = r_state;
    w_rem_next      = r_rem;
    w_src_next      = r_src;
    w_pkt_done_next = 1'b0;
    w_drop_inc      = 1'b0;
    w_push          = 1'b0;
    flit_ready      = 1'b1;
    case (r_state)
      StIdle: begin
        if (w_xfer) begin
          w_src_next = flit_in[27:24];
          w_rem_next = flit_in[23:16];
          if (w_hdr_keep) begin
            if (flit_in[23:16] == 8'd0) w_pkt_done_next = 1'b1;
            else                        w_state_next    = StPayload;
          end else begin
            w_drop_inc = 1'b1;
            if (flit_in[23:16] != 8'd0) w_state_next = StDrop;
          end
        end
      end
      StPayload: begin
        // No full-bypass: a same-cycle pop does not open the port.
        flit_ready = !w_full;
        if (w_xfer) begin
          w_push     = 1'b1;
          w_rem_next = r_rem - 8'd1;
          if (r_rem == 8'd1) begin
            w_state_next    = StIdle;
            w_pkt_done_next = 1'b1;
          end
        end
      end
      StDrop: begin
        if (w_xfer) begin
          w_rem_next = r_rem - 8'd1;
          if (r_rem == 8'd1) w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Parser state, counters and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_rem      <= 8'd0;
      r_src      <= 4'd0;
      r_pkt_done <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_rem      <= w_rem_next;
      r_src      <= w_src_next;
      r_pkt_done <= w_pkt_done_next;
      if (w_drop_inc && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

`ifdef NOC_RX_PARITY_EN
  // Sticky parity error on any checked flit (headers and kept payload).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (w_xfer && !w_par_ok && (r_state != StDrop)) begin
      r_par_err <= 1'b1;
    end
  end
`endif

  // FIFO pointers; reset flushes the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (PTR_W + 1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (PTR_W + 1)'(1);
    end
  end

  // FIFO storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= {r_src, flit_in};
  end

endmodule

// File: tb/tb_noc_rx_port.sv
// Self-checking bench for noc_rx_port: directed scenarios plus random traffic,
// compared every cycle against a queue-based packet-level reference model.
module tb_noc_rx_port;

  localparam int unsigned NodeId = 2;
  localparam int unsigned Depth  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] flit_in;
  logic        flit_valid;
  logic        flit_ready;
  logic        cpu_rd_en;
  logic [31:0] cpu_rd_data;
  logic [3:0]  cpu_rd_src;
  logic        cpu_empty;
  logic        cpu_stall;
  logic        pkt_done;
  logic [7:0]  drop_cnt;
`ifdef NOC_RX_PARITY_EN
  logic        flit_par;
  logic        par_err;
`endif

  noc_rx_port #(
    .NODE_ID   (NodeId),
    .FIFO_DEPTH(Depth),
    .PTR_W     (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flit_in    (flit_in),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .cpu_rd_en  (cpu_rd_en),
    .cpu_rd_data(cpu_rd_data),
    .cpu_rd_src (cpu_rd_src),
    .cpu_empty  (cpu_empty),
    .cpu_stall  (cpu_stall),
    .pkt_done   (pkt_done),
    .drop_cnt   (drop_cnt)
`ifdef NOC_RX_PARITY_EN
    ,
    .flit_par   (flit_par),
    .par_err    (par_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {src, word}, plus the packet currently being parsed.
  logic [35:0] m_q[$];
  bit          m_hdr;   // next flit is a header
  bit          m_keep;  // current packet is for this node
  int          m_left;  // payload flits still to come
  logic [3:0]  m_src;
  bit          m_done;
  int          m_drop;

  logic [31:0] tx_q[$];
  int valid_pct, rd_pct;
  int n_total, n_bad;
  int done_seen;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_hdr || !m_keep || (m_q.size() < Depth);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_hdr  = 1'b1;
    m_keep = 1'b0;
    m_left = 0;
    m_src  = 4'd0;
    m_done = 1'b0;
    m_drop = 0;
  endtask

  task automatic check_outputs();
    check_eq("flit_ready", flit_ready, m_ready());
    check_eq("cpu_empty", cpu_empty, m_q.size() == 0);
    check_eq("cpu_stall", cpu_stall, cpu_rd_en && (m_q.size() == 0));
    check_eq("pkt_done", pkt_done, m_done);
    check_eq("drop_cnt", drop_cnt, m_drop);
    if (m_q.size() > 0) begin
      check_eq("rd_data", cpu_rd_data, m_q[0][31:0]);
      check_eq("rd_src", cpu_rd_src, m_q[0][35:32]);
    end
`ifdef NOC_RX_PARITY_EN
    check_eq("par_err", par_err, 1'b0);
`endif
  endtask

  // One clock: drive at the falling edge, check, then advance the model.
  task automatic cycle();
    bit          xfer, pop;
    logic [31:0] f;
    int          len;
    @(negedge clk);
    flit_valid = (tx_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
    flit_in    = (tx_q.size() > 0) ? tx_q[0] : $urandom();
    cpu_rd_en  = ($urandom_range(0, 99) < rd_pct);
`ifdef NOC_RX_PARITY_EN
    flit_par   = ^flit_in;
`endif
    #1;
    check_outputs();
    if (pkt_done) done_seen++;
    xfer   = flit_valid && m_ready();
    pop    = cpu_rd_en && (m_q.size() > 0);
    m_done = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (xfer) begin
      f = tx_q.pop_front();
      if (m_hdr) begin
        len   = int'(f[23:16]);
        m_src = f[27:24];
        if (f[31:28] == 4'(NodeId)) begin
          if (len == 0) m_done = 1'b1;
          else begin m_hdr = 1'b0; m_keep = 1'b1; m_left = len; end
        end else begin
          if (m_drop < 255) m_drop++;
          if (len > 0) begin m_hdr = 1'b0; m_keep = 1'b0; m_left = len; end
        end
      end else begin
        if (m_keep) m_q.push_back({m_src, f});
        m_left--;
        if (m_left == 0) begin
          m_hdr = 1'b1;
          if (m_keep) m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_pkt(input int dest, input int src, input int len, input logic [31:0] base);
    tx_q.push_back({4'(dest), 4'(src), 8'(len), 16'h0000});
    for (int i = 0; i < len; i++) tx_q.push_back(base + 32'(i));
  endtask

  task automatic drain(input int max);
    int c = 0;
    while (tx_q.size() > 0 && c < max) begin
      cycle();
      c++;
    end
    check_eq("drain_budget", tx_q.size(), 0);
    tx_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    flit_valid = 1'b0;
    cpu_rd_en  = 1'b1;
    #1;
    model_reset();
    tx_q.delete();
    check_eq("rst_ready", flit_ready, 1'b1);
    check_eq("rst_empty", cpu_empty, 1'b1);
    check_eq("rst_stall", cpu_stall, 1'b1);
    check_eq("rst_done", pkt_done, 1'b0);
    check_eq("rst_drop", drop_cnt, 0);
    cpu_rd_en = 1'b0;
    #1;
    check_eq("rst_stall_off", cpu_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int c;
    n_total = 0; n_bad = 0; done_seen = 0;
    rst = 1'b0; flit_valid = 1'b0; flit_in = '0; cpu_rd_en = 1'b0;
`ifdef NOC_RX_PARITY_EN
    flit_par = 1'b0;
`endif
    model_reset();
    do_reset();
    valid_pct = 100; rd_pct = 0;

    // Own 3-flit packet, then read it back.
    done_seen = 0;
    send_pkt(2, 1, 3, 32'hA);
    drain(20);
    cycles(2);
    check_eq("t1_done_once", done_seen, 1);
    check_eq("t1_head", cpu_rd_data, 32'hA);
    check_eq("t1_src", cpu_rd_src, 4'd1);
    rd_pct = 100;
    cycles(4);
    check_eq("t1_empty", cpu_empty, 1'b1);
    rd_pct = 0;

    // Foreign packet is swallowed.
    done_seen = 0;
    send_pkt(5, 3, 4, 32'h100);
    drain(20);
    cycles(2);
    check_eq("t2_no_done", done_seen, 0);
    check_eq("t2_drop", drop_cnt, 8'd1);
    check_eq("t2_empty", cpu_empty, 1'b1);

    // Overflow back-pressure with a 10-flit packet.
    done_seen = 0;
    send_pkt(2, 7, 10, 32'h200);
    cycles(12);
    check_eq("t3_full_block", flit_ready, 1'b0);
    rd_pct = 100; cycle(); rd_pct = 0;
    cycle();
    check_eq("t3_reopen", flit_ready, 1'b1);
    cycle();
    check_eq("t3_not_done", done_seen, 0);
    rd_pct = 100; cycle(); rd_pct = 0;
    cycles(3);
    check_eq("t3_done", done_seen, 1);
    rd_pct = 100;
    cycles(10);
    check_eq("t3_empty", cpu_empty, 1'b1);

    // Stall while empty, released by a 1-flit packet.
    cycles(3);
    check_eq("t4_stall", cpu_stall, 1'b1);
    send_pkt(2, 4, 1, 32'h1234);
    c = 0;
    do begin cycle(); c++; end while (cpu_stall && c < 10);
    check_eq("t4_release", cpu_stall, 1'b0);
    check_eq("t4_data", cpu_rd_data, 32'h1234);
    rd_pct = 0;
    cycles(2);

    // Zero-length own packet, then drop counter saturation.
    done_seen = 0;
    send_pkt(2, 9, 0, 32'h0);
    drain(10);
    cycles(2);
    check_eq("t5_done", done_seen, 1);
    check_eq("t5_empty", cpu_empty, 1'b1);
    for (int i = 0; i < 256; i++) send_pkt((NodeId + 1 + i % 15) % 16, i % 16, 0, 32'h0);
    drain(400);
    cycles(1);
    check_eq("t5_sat", drop_cnt, 8'd255);

    // Reset in the middle of a packet.
    do_reset();
    send_pkt(2, 6, 5, 32'h500);
    c = 0;
    while (!(m_hdr == 1'b0 && m_left == 3) && c < 20) begin cycle(); c++; end
    check_eq("t6_mid", m_left, 3);
    do_reset();
    check_eq("t6_idle", flit_ready, 1'b1);
    send_pkt(2, 8, 2, 32'h600);
    drain(20);
    cycles(1);
    check_eq("t6_head", cpu_rd_data, 32'h600);
    check_eq("t6_src", cpu_rd_src, 4'd8);
    rd_pct = 100;
    cycles(4);

    // Random traffic.
    for (int p = 0; p < 200; p++) begin
      valid_pct = $urandom_range(50, 100);
      rd_pct    = $urandom_range(20, 90);
      send_pkt(($urandom_range(0, 1) == 0) ? NodeId : $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 12), $urandom());
      drain(400);
    end
    rd_pct = 100;
    cycles(Depth + 2);
    check_eq("rand_empty", cpu_empty, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
